act8_1by4_gl: RTL and testbench

ACT8_1BY4_GL -- requirements
Module: act8_1by4_gl

---
 rtl/act8_1by4_gl.sv | 50 +++++
 tb/tb_act8_1by4_gl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/act8_1by4_gl.sv
// 1-to-4 demultiplexer: D is routed to Y[{S1,S0}], the other outputs are zero.
// Define ACT8_1BY4_GL_COMB_OUT_EN for a purely combinational build (clk/rst_n ignored).
module act8_1by4_gl #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  input  logic             S1,
  input  logic             S0,
  input  logic [WIDTH-1:0] D,
  input  logic             clk,
  input  logic             rst_n
);

  function automatic logic [3:0][WIDTH-1:0] route(input logic [1:0] sel,
                                                  input logic [WIDTH-1:0] d);
    route      = '0;
    route[sel] = d;
  endfunction

  logic [1:0]            sel;
  logic [3:0][WIDTH-1:0] y_p0;

  assign sel = {S1, S0};

`ifdef ACT8_1BY4_GL_COMB_OUT_EN
  logic unused_ctrl;

  assign unused_ctrl = clk & rst_n;
  assign y_p0        = route(sel, D);
`else
  // Stage p0: the whole output word is one register, so one edge both clears
  // the old selection and loads the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p0 <= '0;
    end else begin
      y_p0 <= route(sel, D);
    end
  end
`endif

  assign Y0 = y_p0[0];
  assign Y1 = y_p0[1];
  assign Y2 = y_p0[2];
  assign Y3 = y_p0[3];

endmodule

// File: tb/tb_act8_1by4_gl.sv
// Scoreboard bench for act8_1by4_gl: WIDTH=1 and WIDTH=8 instances share the selects.
module tb_act8_1by4_gl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s1 = 1'b1;
  logic       s0 = 1'b1;
  logic [0:0] d = 1'b1;
  logic [7:0] d8 = 8'h00;
  logic [0:0] y0, y1, y2, y3;
  logic [7:0] w0, w1, w2, w3;

  int errors = 0;
  int checks = 0;

  logic [3:0]  q1[$];
  logic [31:0] q8[$];

  act8_1by4_gl #(.WIDTH(1)) dut1 (
    .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3),
    .S1(s1), .S0(s0), .D(d), .clk(clk), .rst_n(rst_n)
  );

  act8_1by4_gl #(.WIDTH(8)) dut8 (
    .Y0(w0), .Y1(w1), .Y2(w2), .Y3(w3),
    .S1(s1), .S0(s0), .D(d8), .clk(clk), .rst_n(rst_n)
  );

`ifndef ACT8_1BY4_GL_COMB_OUT_EN
  always #5 clk = ~clk;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic a1, input logic a0, input logic dv, input logic [7:0] dw);
    int idx;
    s1  = a1;
    s0  = a0;
    d   = dv;
    d8  = dw;
    idx = {a1, a0};
    q1.push_back(dv ? (4'b0001 << idx) : 4'b0000);
    q8.push_back(32'(dw) << (8 * idx));
  endtask

  task automatic compare(input string tag);
    logic [3:0]  e1;
    logic [31:0] e8;
    if (q1.size() == 0 || q8.size() == 0) begin
      check({tag, "_empty"}, 32'(q1.size() + q8.size()), 32'd2);
    end else begin
      e1 = q1.pop_front();
      e8 = q8.pop_front();
      check({tag, "_w1"}, {28'd0, y3, y2, y1, y0}, {28'd0, e1});
      check({tag, "_w8"}, {w3, w2, w1, w0}, e8);
    end
  endtask

  // One registered transaction: drive on the falling edge, compare 1 after rising.
  task automatic cycle(input string tag, input logic a1, input logic a0,
                       input logic dv, input logic [7:0] dw);
    @(negedge clk);
    drive(a1, a0, dv, dw);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ACT8_1BY4_GL_COMB_OUT_EN
    for (int v = 0; v < 8; v++) begin
      drive(v[2], v[1], v[0], v[0] ? 8'h5A : 8'h00);
      #1;
      compare($sformatf("comb_sweep%0d", v));
    end
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 8'hA5);
    #1;
    compare("comb_ignores_rst");
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom));
      #1;
      compare($sformatf("comb_rand%0d", i));
    end
`else
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", {28'd0, y3, y2, y1, y0}, 32'd0);
    check("reset_async_w8", {w3, w2, w1, w0}, 32'd0);
    d8 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {28'd0, y3, y2, y1, y0}, 32'd0);
    check("reset_hold_w8", {w3, w2, w1, w0}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 8'h3C);
    @(posedge clk);
    #1;
    compare("first_after_reset");

    for (int v = 0; v < 8; v++)
      cycle($sformatf("sweep%0d", v), v[2], v[1], v[0], v[0] ? 8'h5A : 8'h00);

    cycle("width8", 1'b1, 1'b0, 1'b1, 8'hA5);

    cycle("hold_load", 1'b1, 1'b0, 1'b1, 8'hC3);
    #2;
    d  = 1'b0;
    d8 = 8'h00;
    s1 = 1'b0;
    #2;
    check("hold_mid", {28'd0, y3, y2, y1, y0}, 32'h4);
    check("hold_mid_w8", {w3, w2, w1, w0}, 32'h00C3_0000);
    cycle("hold_next", 1'b1, 1'b0, 1'b0, 8'h00);

    cycle("y3_load", 1'b1, 1'b1, 1'b1, 8'h81);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {28'd0, y3, y2, y1, y0}, 32'd0);
    check("midrun_reset_w8", {w3, w2, w1, w0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 8'h11);
    @(posedge clk);
    #1;
    compare("midrun_release");

    for (int i = 0; i < 12; i++)
      cycle($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom));
`endif
    check("queue_drained", 32'(q1.size() + q8.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
